// File: rtl/cpu6_mem_arbiter.sv
// cpu6_mem_arbiter: shares RAM port B between the core load/store path and a DMA master.
// One access per cycle, grants are combinational, and read data returns one cycle later.
// Ties go round-robin, and a locked DMA burst is capped at MAX_LOCK grants.
// Optional macro CPU6_MEMARB_RANGECHK_EN adds err_oob and suppresses out-of-range accesses.
module cpu6_mem_arbiter #(
    parameter int unsigned AW       = 11,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [31:0]   core_addr,
    input  logic [31:0]   core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [31:0]   core_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [31:0]   dma_addr,
    input  logic [31:0]   dma_wdata,
    input  logic          dma_lock,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
`ifdef CPU6_MEMARB_RANGECHK_EN
    output logic          err_oob,
`endif
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LockMax = CW'(MAX_LOCK);

    typedef enum logic [1:0] {StIdle, StCore, StDma, StDmaLock} state_t;

    state_t        state;
    logic          last_dma;   // owner of the most recent grant; survives idle cycles
    logic [CW-1:0] lock_cnt;
    logic          core_pend;
    logic          dma_pend;
    logic          win_core;
    logic [31:0]   sel_addr;
    logic          sel_we;
    logic          oob;

    // Arbitration: a single requester always wins; ties use round-robin or the burst lock
    always_comb begin
        win_core = 1'b0;
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (!reset) begin
            if (core_req && dma_req) begin
                if (state == StDmaLock) begin
                    win_core = (lock_cnt == LockMax);
                end else begin
                    win_core = last_dma;
                end
                core_gnt = win_core;
                dma_gnt  = ~win_core;
            end else begin
                core_gnt = core_req;
                dma_gnt  = dma_req;
            end
        end
    end

    // RAM port B mux; the address and data are don't-care when nothing is granted
    always_comb begin
        sel_addr  = dma_gnt ? dma_addr  : core_addr;
        sel_we    = dma_gnt ? dma_we    : core_we;
        ram_wdata = dma_gnt ? dma_wdata : core_wdata;
        ram_addr  = sel_addr[AW+1:2];
`ifdef CPU6_MEMARB_RANGECHK_EN
        oob       = |sel_addr[31:AW+2];
`else
        oob       = 1'b0;
`endif
        ram_we    = (core_gnt | dma_gnt) & sel_we & ~oob;
        core_stall = core_req & ~core_gnt;
    end

`ifdef CPU6_MEMARB_RANGECHK_EN
    logic core_oob;
    logic dma_oob;
    logic err_q;
    logic unused_addr;
    assign unused_addr = ^sel_addr[1:0];

    // Out-of-range bookkeeping: reads return a marker word, and any such access flags an error
    always_ff @(posedge clk) begin
        if (reset) begin
            core_oob <= 1'b0;
            dma_oob  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            core_oob <= core_gnt & oob;
            dma_oob  <= dma_gnt & oob;
            err_q    <= (core_gnt | dma_gnt) & oob;
        end
    end

    assign err_oob = err_q & ~reset;
`else
    logic core_oob;
    logic dma_oob;
    logic unused_addr;
    assign core_oob    = 1'b0;
    assign dma_oob     = 1'b0;
    assign unused_addr = ^{sel_addr[1:0], sel_addr[31:AW+2], oob};
`endif

    // FSM, ownership history, burst counter and read-pending flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            last_dma  <= 1'b1;
            lock_cnt  <= '0;
            core_pend <= 1'b0;
            dma_pend  <= 1'b0;
        end else begin
            core_pend <= core_gnt & ~core_we;
            dma_pend  <= dma_gnt & ~dma_we;
            if (core_gnt) begin
                state    <= StCore;
                last_dma <= 1'b0;
                lock_cnt <= '0;
            end else if (dma_gnt) begin
                last_dma <= 1'b1;
                if (dma_lock) begin
                    state <= StDmaLock;
                    if (lock_cnt != LockMax) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end else begin
                    state    <= StDma;
                    lock_cnt <= '0;
                end
            end else begin
                state    <= StIdle;
                lock_cnt <= '0;
            end
        end
    end

    // Read return; reset wins over a read still in flight
    always_comb begin
        core_rvalid = core_pend & ~reset;
        dma_rvalid  = dma_pend & ~reset;
        core_rdata  = '0;
        dma_rdata   = '0;
        if (core_rvalid) begin
            core_rdata = core_oob ? 32'hDEADBEEF : ram_rdata;
        end
        if (dma_rvalid) begin
            dma_rdata = dma_oob ? 32'hDEADBEEF : ram_rdata;
        end
    end

endmodule

// File: tb/tb_cpu6_mem_arbiter.sv
// Bench for cpu6_mem_arbiter: a behavioural RAM, a request-level model of the arbitration
// rules with a shadow memory, directed scenarios with literal expectations, then random traffic.
module tb_cpu6_mem_arbiter;

    localparam int AW = 11;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [31:0]   core_addr, core_wdata, core_rdata;
    logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0]   dma_addr, dma_wdata, dma_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;
`ifdef CPU6_MEMARB_RANGECHK_EN
    logic          err_oob;
`endif

    always #5 clk = ~clk;

    cpu6_mem_arbiter #(.AW(AW), .MAX_LOCK(ML)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_stall (core_stall),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
`ifdef CPU6_MEMARB_RANGECHK_EN
        .err_oob    (err_oob),
`endif
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Port B of the RAM: registered read, one-cycle latency
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model state
    logic [31:0] shadow [0:(1<<AW)-1];
    bit          m_last_dma;
    int          m_run;       // consecutive locked DMA grants just made
    bit          m_cp, m_dp, m_err;
    logic [31:0] m_ce, m_de;

    int n_tests = 0;
    int n_fail  = 0;

    // Samples of the last step, for literal checks
    logic        s_cg, s_dg, s_cs, s_cv, s_dv, s_we, s_err;
    logic [31:0] s_cd, s_dd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] a);
`ifdef CPU6_MEMARB_RANGECHK_EN
        return |a[31:AW+2];
`else
        return a[0] & 1'b0;
`endif
    endfunction

    // One clock: compare at the falling edge against the model, then advance the model
    task automatic step();
        bit gc, gd, co, dox;
        int ci, di;
        @(negedge clk);
        gc = 0;
        gd = 0;
        if (!reset) begin
            if (core_req && dma_req) begin
                if (m_run > 0) gc = (m_run >= ML);
                else gc = m_last_dma;
                gd = !gc;
            end else begin
                gc = core_req;
                gd = dma_req;
            end
        end
        co  = is_oob(core_addr);
        dox = is_oob(dma_addr);
        ci  = int'(core_addr[AW+1:2]);
        di  = int'(dma_addr[AW+1:2]);

        s_cg = core_gnt;   s_dg = dma_gnt;   s_cs = core_stall; s_we = ram_we;
        s_cv = core_rvalid; s_dv = dma_rvalid; s_cd = core_rdata; s_dd = dma_rdata;
`ifdef CPU6_MEMARB_RANGECHK_EN
        s_err = err_oob;
        check("err_oob", err_oob, m_err && !reset);
`else
        s_err = 1'b0;
`endif
        check("core_gnt", core_gnt, gc);
        check("dma_gnt", dma_gnt, gd);
        check("core_stall", core_stall, core_req && !gc);
        check("ram_we", ram_we, (gc && core_we && !co) || (gd && dma_we && !dox));
        if (gc) begin
            check("ram_addr_core", ram_addr, core_addr[AW+1:2]);
            if (core_we) check("ram_wdata_core", ram_wdata, core_wdata);
        end
        if (gd) begin
            check("ram_addr_dma", ram_addr, dma_addr[AW+1:2]);
            if (dma_we) check("ram_wdata_dma", ram_wdata, dma_wdata);
        end
        check("core_rvalid", core_rvalid, m_cp && !reset);
        check("core_rdata", core_rdata, (m_cp && !reset) ? m_ce : 32'h0);
        check("dma_rvalid", dma_rvalid, m_dp && !reset);
        check("dma_rdata", dma_rdata, (m_dp && !reset) ? m_de : 32'h0);

        if (reset) begin
            m_last_dma = 1;
            m_run = 0;
            m_cp = 0;
            m_dp = 0;
            m_err = 0;
        end else begin
            m_cp  = gc && !core_we;
            m_dp  = gd && !dma_we;
            m_err = (gc && co) || (gd && dox);
            if (gc) begin
                m_ce = co ? 32'hDEADBEEF : shadow[ci];
                if (core_we && !co) shadow[ci] = core_wdata;
                m_last_dma = 0;
                m_run = 0;
            end else if (gd) begin
                m_de = dox ? 32'hDEADBEEF : shadow[di];
                if (dma_we && !dox) shadow[di] = dma_wdata;
                m_last_dma = 1;
                m_run = dma_lock ? ((m_run < ML) ? m_run + 1 : ML) : 0;
            end else begin
                m_run = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [10:0] w;
        logic [1:0]  b;
        if ($urandom_range(0, 7) == 0) return $urandom;
        w = 11'($urandom_range(0, 31));
        b = 2'($urandom_range(0, 3));
        return {19'h0, w, b};
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        ram_rdata = '0;
        m_last_dma = 1; m_run = 0; m_cp = 0; m_dp = 0; m_err = 0; m_ce = '0; m_de = '0;
        reset = 1;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;
        #1;

        // Reset state, and no grant while reset is high
        step();
        core_req = 1;
        step();
        check("lit_reset_gnt", s_cg, 1'b0);
        check("lit_reset_we", s_we, 1'b0);
        check("lit_reset_rvalid", s_cv, 1'b0);

        // Core write then read of 0x10
        reset = 0;
        core_we = 1; core_addr = 32'h10; core_wdata = 32'hCAFEF00D;
        step();
        check("lit_wr_gnt", s_cg, 1'b1);
        check("lit_wr_we", s_we, 1'b1);
        core_we = 0;
        step();
        check("lit_rd_gnt", s_cg, 1'b1);
        check("lit_rd_stall", s_cs, 1'b0);
        core_req = 0;
        step();
        check("lit_rd_rvalid", s_cv, 1'b1);
        check("lit_rd_data", s_cd, 32'hCAFEF00D);

        // Round-robin right after reset: core, DMA, core, DMA
        reset = 1;
        step();
        reset = 0;
        core_req = 1; core_we = 0; core_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h40; dma_lock = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lit_rr_core", s_cg, (i % 2) == 0);
            check("lit_rr_dma", s_dg, (i % 2) == 1);
        end

        // Locked burst: core, 16 DMA, core, DMA
        reset = 1;
        step();
        reset = 0;
        dma_lock = 1;
        for (int i = 0; i < 19; i++) begin
            step();
            check("lit_lock_core", s_cg, (i == 0) || (i == 17));
            if (i >= 1 && i <= 16) check("lit_lock_stall", s_cs, 1'b1);
        end

        // DMA write immediately before a core read of the same word
        core_req = 0; dma_lock = 0;
        dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h11111111;
        step();
        check("lit_dmawr_gnt", s_dg, 1'b1);
        dma_req = 0;
        core_req = 1; core_we = 0; core_addr = 32'h20;
        step();
        core_req = 0;
        step();
        check("lit_dmawr_data", s_cd, 32'h11111111);

        // Reset the cycle after a granted core read
        core_req = 1; core_addr = 32'h10;
        step();
        check("lit_rst_rd_gnt", s_cg, 1'b1);
        core_req = 0; reset = 1;
        step();
        check("lit_rst_rvalid0", s_cv, 1'b0);
        reset = 0;
        step();
        check("lit_rst_rvalid1", s_cv, 1'b0);
        core_req = 1; dma_req = 1; dma_we = 0;
        step();
        check("lit_rst_tie_core", s_cg, 1'b1);
        core_req = 0; dma_req = 0;
        step();

`ifdef CPU6_MEMARB_RANGECHK_EN
        // Out-of-range write is dropped and flagged
        core_req = 1; core_we = 1; core_addr = 32'h0001_0000; core_wdata = 32'h12345678;
        step();
        check("lit_oob_gnt", s_cg, 1'b1);
        check("lit_oob_we", s_we, 1'b0);
        core_we = 0; core_addr = 32'h0;
        step();
        check("lit_oob_err", s_err, 1'b1);
        core_req = 0;
        step();
        check("lit_oob_word0", s_cd, 32'h0);
        check("lit_oob_err_once", s_err, 1'b0);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            dma_lock = ($urandom_range(0, 15) != 0);
            if (!core_req || s_cg) begin
                core_req = ($urandom_range(0, 3) != 0);
                core_we = 1'($urandom_range(0, 1));
                core_addr = rand_addr();
                core_wdata = $urandom;
            end
            if (!dma_req || s_dg) begin
                dma_req = ($urandom_range(0, 15) != 0);
                dma_we = 1'($urandom_range(0, 1));
                dma_addr = rand_addr();
                dma_wdata = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
